// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: the CPU load/store port, the cash_mem data-array
// port, the main-memory handshake and the read hit/miss counters.
//   slave  : the controller side (cache_ctrl)
//   master : the environment side (CPU, cash_mem, main memory)
interface cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU port
  logic                cpu_rd;
  logic                cpu_wr;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                stall;
  // cash_mem data array
  logic [ADDR_W-1:0]   cache_addr;
  logic [4*DATA_W-1:0] cache_din;
  logic                cache_we;
  logic                read_miss;
  // main memory
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [4*DATA_W-1:0] mem_rdata;
  logic                mem_ready;
  // statistics
  logic [31:0]         rd_hit_cnt;
  logic [31:0]         rd_miss_cnt;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output stall, cache_addr, cache_din, cache_we, read_miss,
           mem_rd, mem_wr, mem_addr, mem_wdata, rd_hit_cnt, rd_miss_cnt
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  stall, cache_addr, cache_din, cache_we, read_miss,
           mem_rd, mem_wr, mem_addr, mem_wdata, rd_hit_cnt, rd_miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencer for a direct-mapped cache with 4-word lines (cash_mem data array).
// Holds tag/valid arrays, detects hits, stalls the CPU and refills a whole
// line from main memory on a read miss. Writes are write-through,
// no-write-allocate.
//
// Ports
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   bus  : cache_ctrl_if.slave (CPU port, cash_mem port, main-memory
//          handshake, rd_hit_cnt / rd_miss_cnt statistics)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | serve hits combinationally, accept a new miss or store
// S_RD_MISS | line read outstanding on main memory, waiting for mem_ready
// S_REFILL  | one cycle: write fetched line into cash_mem, update tag/valid
// S_WR_WAIT | word write-through outstanding, waiting for mem_ready
module cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LENGTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  cache_ctrl_if.slave   bus
);
  localparam int LINES = LENGTH / 4;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_REFILL  = 2'd2,
    S_WR_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [4*DATA_W-1:0] line_q, line_d;
  logic [31:0]         rd_hit_cnt_q, rd_hit_cnt_d;
  logic [31:0]         rd_miss_cnt_q, rd_miss_cnt_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];

  logic [IDX_W-1:0]    cpu_idx, lat_idx;
  logic [TAG_W-1:0]    cpu_tag, lat_tag;
  logic                hit;
  logic                fill_en;

  assign cpu_idx = bus.cpu_addr[IDX_W+1:2];
  assign cpu_tag = bus.cpu_addr[ADDR_W-1:IDX_W+2];
  assign lat_idx = addr_q[IDX_W+1:2];
  assign lat_tag = addr_q[ADDR_W-1:IDX_W+2];
  assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      line_q        <= '0;
      rd_hit_cnt_q  <= '0;
      rd_miss_cnt_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      line_q        <= line_d;
      rd_hit_cnt_q  <= rd_hit_cnt_d;
      rd_miss_cnt_q <= rd_miss_cnt_d;
      if (fill_en) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Tags need no reset: a tag is only consulted once its valid bit is set.
  // fill_en is only high in S_REFILL, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[lat_idx] <= lat_tag;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    line_d        = line_q;
    rd_hit_cnt_d  = rd_hit_cnt_q;
    rd_miss_cnt_d = rd_miss_cnt_q;
    fill_en       = 1'b0;

    bus.stall      = 1'b0;
    bus.cache_addr = addr_q;
    bus.cache_din  = {{(3*DATA_W){1'b0}}, wdata_q};
    bus.cache_we   = 1'b0;
    bus.read_miss  = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.cache_addr = bus.cpu_addr;
        bus.cache_din  = {{(3*DATA_W){1'b0}}, bus.cpu_wdata};
        // Store wins over load; a store hit updates the word in place now,
        // the memory write-through follows in S_WR_WAIT.
        if (bus.cpu_wr) begin
          bus.stall    = 1'b1;
          bus.cache_we = hit;
          addr_d       = bus.cpu_addr;
          wdata_d      = bus.cpu_wdata;
          state_d      = S_WR_WAIT;
        end else if (bus.cpu_rd) begin
          if (hit) begin
            rd_hit_cnt_d = sat_inc(rd_hit_cnt_q);
          end else begin
            bus.stall     = 1'b1;
            addr_d        = bus.cpu_addr;
            rd_miss_cnt_d = sat_inc(rd_miss_cnt_q);
            state_d       = S_RD_MISS;
          end
        end
      end
      S_RD_MISS: begin
        bus.stall    = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (bus.mem_ready) begin
          line_d  = bus.mem_rdata;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        bus.stall     = 1'b1;
        bus.cache_we  = 1'b1;
        bus.read_miss = 1'b1;
        bus.cache_din = line_q;
        fill_en       = 1'b1;
        state_d       = S_IDLE;
      end
      S_WR_WAIT: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        // Release the CPU in the completion cycle so the store costs no
        // extra cycle after mem_ready.
        bus.stall     = !bus.mem_ready;
        if (bus.mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_hit_cnt  = rd_hit_cnt_q;
  assign bus.rd_miss_cnt = rd_miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // handshakes between processes (each variable written by one process)
  int fixed_lat   = -1;
  int inject_seq  = 0, inject_done = 0;
  int preset_seq  = 0, preset_done = 0;
  int pin_seq     = 0, pin_done    = 0;
  logic [31:0] pin_hit, pin_miss;
  int line_pin_seq = 0, line_pin_done = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [127:0] mkline(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {memw(b + 3), memw(b + 2), memw(b + 1), memw(b)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main-memory responder ----------------
  int          busy = 0, cnt = 0;
  logic [31:0] raddr;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      if (inject_seq != inject_done) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mkline(32'h40);
        inject_done   = inject_seq;
      end else if (rst) begin
        busy = 0;
      end else if (busy != 0) begin
        if (cnt <= 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mkline(raddr);
          busy = 0;
        end else cnt--;
      end else if (bus.mem_rd || bus.mem_wr) begin
        busy  = 1;
        raddr = bus.mem_addr;
        cnt   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_valid [32];
  logic [24:0] m_tag   [32];
  longint      m_hit, m_miss;
  int          m_mode;      // 0 free, 1 awaiting line, 2 writing line, 3 awaiting store ack
  logic [31:0] m_paddr, m_pdata;
  logic [127:0] m_line;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'd31);
  endfunction
  function automatic logic [24:0] tag_of(input logic [31:0] a);
    return a[31:7];
  endfunction

  initial begin
    bit m_h;
    logic e_stall, e_we, e_rm, e_mrd, e_mwr;
    logic [31:0] e_caddr, e_maddr, e_mwd;
    logic [127:0] e_cdin;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_cache_we", bus.cache_we, 0);
        chk("rst_hit_cnt", bus.rd_hit_cnt, 0);
        chk("rst_miss_cnt", bus.rd_miss_cnt, 0);
      end else begin
        if (preset_seq != preset_done) begin
          m_hit = 64'hFFFF_FFFD;
          preset_done = preset_seq;
        end
        m_h     = m_valid[idx_of(bus.cpu_addr)] && (m_tag[idx_of(bus.cpu_addr)] == tag_of(bus.cpu_addr));
        e_stall = 0; e_we = 0; e_rm = 0; e_mrd = 0; e_mwr = 0;
        e_maddr = 0; e_mwd = 0;
        e_caddr = m_paddr;
        e_cdin  = {96'b0, m_pdata};
        case (m_mode)
          0: begin
            e_caddr = bus.cpu_addr;
            e_cdin  = {96'b0, bus.cpu_wdata};
            if (bus.cpu_wr) begin
              e_stall = 1; e_we = m_h;
            end else if (bus.cpu_rd) e_stall = !m_h;
          end
          1: begin
            e_stall = 1; e_mrd = 1; e_maddr = m_paddr & ~32'd3;
          end
          2: begin
            e_stall = 1; e_we = 1; e_rm = 1; e_cdin = m_line;
          end
          default: begin
            e_mwr = 1; e_maddr = m_paddr; e_mwd = m_pdata; e_stall = !bus.mem_ready;
          end
        endcase
        chk("stall", bus.stall, e_stall);
        chk("cache_we", bus.cache_we, e_we);
        chk("read_miss", bus.read_miss, e_rm);
        chk("mem_rd", bus.mem_rd, e_mrd);
        chk("mem_wr", bus.mem_wr, e_mwr);
        chk("mem_addr", bus.mem_addr, e_maddr);
        chk("mem_wdata", bus.mem_wdata, e_mwd);
        chk("cache_addr", bus.cache_addr, e_caddr);
        chk("cache_din", bus.cache_din, e_cdin);
        chk("rd_hit_cnt", bus.rd_hit_cnt, m_hit[31:0]);
        chk("rd_miss_cnt", bus.rd_miss_cnt, m_miss[31:0]);
        // literal pins on the first refill of line 0x40
        if (line_pin_seq != line_pin_done) begin
          if (m_mode == 1) chk("pin_mem_addr_40", bus.mem_addr, 32'h40);
          if (m_mode == 2) begin
            chk("pin_refill_line_40", bus.cache_din,
                128'hA5000043_A5000042_A5000041_A5000040);
            chk("pin_refill_we_rm", {bus.cache_we, bus.read_miss}, 2'b11);
            line_pin_done = line_pin_seq;
          end
        end
        if (pin_seq != pin_done) begin
          chk("pin_hit_cnt", bus.rd_hit_cnt, pin_hit);
          chk("pin_miss_cnt", bus.rd_miss_cnt, pin_miss);
          pin_done = pin_seq;
        end
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
        m_hit = 0; m_miss = 0; m_mode = 0;
        m_paddr = 0; m_pdata = 0; m_line = 0;
      end else begin
        case (m_mode)
          0: begin
            m_h = m_valid[idx_of(bus.cpu_addr)] && (m_tag[idx_of(bus.cpu_addr)] == tag_of(bus.cpu_addr));
            if (bus.cpu_wr) begin
              m_paddr = bus.cpu_addr; m_pdata = bus.cpu_wdata; m_mode = 3;
            end else if (bus.cpu_rd) begin
              if (m_h) m_hit = (m_hit < 64'hFFFF_FFFF) ? m_hit + 1 : m_hit;
              else begin
                m_miss  = (m_miss < 64'hFFFF_FFFF) ? m_miss + 1 : m_miss;
                m_paddr = bus.cpu_addr;
                m_mode  = 1;
              end
            end
          end
          1: if (bus.mem_ready) begin m_line = bus.mem_rdata; m_mode = 2; end
          2: begin
            m_valid[idx_of(m_paddr)] = 1;
            m_tag[idx_of(m_paddr)]   = tag_of(m_paddr);
            m_mode = 0;
          end
          default: if (bus.mem_ready) m_mode = 0;
        endcase
      end
    end
  end

  // ---------------- CPU driver ----------------
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic s;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int n = 0; ; n++) begin
      @(negedge clk); s = bus.stall;
      @(posedge clk); #1;
      if (!s) break;
      if (n > 60) begin
        $display("FAIL stall_timeout actual=stuck required=release addr=%0h", a);
        $fatal(1, "stall never released");
      end
    end
    bus.cpu_rd = 0; bus.cpu_wr = 0;
  endtask

  task automatic idle_cycle();
    bus.cpu_rd = 0; bus.cpu_wr = 0;
    @(posedge clk); #1;
  endtask

  task automatic pin_counts(input logic [31:0] h, input logic [31:0] m);
    pin_hit = h; pin_miss = m; pin_seq++;
    idle_cycle();
  endtask

  initial begin
    int k;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;

    // 1: cold miss on 0x40, refill, then the whole line hits
    fixed_lat = 3;
    line_pin_seq++;
    cpu_op(1, 0, 32'h40, 32'h0);
    for (int i = 1; i < 4; i++) cpu_op(1, 0, 32'h40 + i, 32'h0);
    fixed_lat = -1;
    pin_counts(4, 1);

    // 2: conflict on index 16
    cpu_op(1, 0, 32'h40, 0);
    cpu_op(1, 0, 32'hC0, 0);
    cpu_op(1, 0, 32'h40, 0);
    pin_counts(7, 3);

    // 3: store hit and store miss
    cpu_op(0, 1, 32'h42, 32'hDEAD);
    cpu_op(0, 1, 32'h200, 32'h1234_5678);
    // 4: store wins over load
    cpu_op(1, 1, 32'h40, 32'hBEEF);
    pin_counts(7, 3);

    // random traffic on a small address pool to mix hits, misses, conflicts
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      k = int'($urandom_range(0, 99));
      if (k < 55)      cpu_op(1, 0, a, $urandom);
      else if (k < 80) cpu_op(0, 1, a, $urandom);
      else if (k < 88) cpu_op(1, 1, a, $urandom);
      else             idle_cycle();
    end

    // 5: reset in the middle of a refill request
    fixed_lat = 20;
    bus.cpu_rd = 1; bus.cpu_addr = 32'h40;
    @(posedge clk); @(posedge clk); #3;
    rst = 1; bus.cpu_rd = 0;
    @(posedge clk); #2;
    rst = 0;
    fixed_lat = -1;
    inject_seq++;
    repeat (3) @(posedge clk);
    #1;
    cpu_op(1, 0, 32'h40, 0);
    pin_counts(1, 1);

    // 6: hit counter saturation
    @(posedge clk); #2;
    force dut.rd_hit_cnt_q = 32'hFFFF_FFFD;
    preset_seq++;
    #1 release dut.rd_hit_cnt_q;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cpu_op(1, 0, 32'h41, 0);
    pin_counts(32'hFFFF_FFFF, 1);

    repeat (2) idle_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
